// File: rtl/ball_paddle_ctrl.sv
// Breakout per-frame game controller: paddle and ball motion, bounces, misses and lives.
// Every register advances once per frame, at the first pixel of vertical blanking.
module ball_paddle_ctrl #(
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 64,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_STEP   = 2,
  parameter int LIVES_INIT  = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pTick,
  input  logic [9:0] pixelX,
  input  logic [9:0] pixelY,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnServe,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic [9:0] paddleX,
  output logic [1:0] lives,
  output logic [1:0] gameState,
  output logic       paddleHit,
  output logic       frameTick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_MISS = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(MISS_FRAMES + 1);

  localparam logic [10:0] L_HV    = 11'(H_VISIBLE);
  localparam logic [10:0] L_VV    = 11'(V_VISIBLE);
  localparam logic [10:0] L_BS    = 11'(BALL_SIZE);
  localparam logic [10:0] L_PW    = 11'(PADDLE_W);
  localparam logic [10:0] L_PY    = 11'(PADDLE_Y);
  localparam logic [10:0] L_PSTEP = 11'(PADDLE_STEP);
  localparam logic [10:0] L_BSTEP = 11'(BALL_STEP);
  localparam logic [10:0] L_PMAX  = 11'(H_VISIBLE - PADDLE_W);

  localparam logic [9:0] PADDLE_HOME = 10'((H_VISIBLE - PADDLE_W) / 2);
  localparam logic [9:0] PADDLE_MAX  = 10'(H_VISIBLE - PADDLE_W);
  localparam logic [9:0] PARK_OFS    = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PARK_Y      = 10'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0] FLOOR_Y     = 10'(V_VISIBLE - BALL_SIZE);
  localparam logic [9:0] WALL_X      = 10'(H_VISIBLE - BALL_SIZE);
  localparam logic [9:0] P_STEP      = 10'(PADDLE_STEP);
  localparam logic [9:0] B_STEP      = 10'(BALL_STEP);

  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);
  localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

  state_t           r_state;
  logic [1:0]       r_lives;
  logic [9:0]       r_paddleX;
  logic [9:0]       r_ballX;
  logic [9:0]       r_ballY;
  logic             r_dirRight;
  logic             r_dirUp;
  logic [CNT_W-1:0] r_missCnt;
  logic             r_frameTick;
  logic             r_paddleHit;

  logic        w_update;
  logic [10:0] w_px;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic [9:0]  w_paddleNext;
  logic [9:0]  w_ballXNext;
  logic [9:0]  w_ballYNext;
  logic        w_dirRightNext;
  logic        w_dirUpNext;
  logic        w_hit;
  logic        w_miss;

  assign w_update = pTick && (pixelX == 10'd0) && ({1'b0, pixelY} == L_VV);
  assign w_px     = {1'b0, r_paddleX};
  assign w_bx     = {1'b0, r_ballX};
  assign w_by     = {1'b0, r_ballY};

  always_comb begin
    w_paddleNext = r_paddleX;
    if (btnLeft && !btnRight) begin
      if (w_px < L_PSTEP) w_paddleNext = 10'd0;
      else                w_paddleNext = r_paddleX - P_STEP;
    end else if (btnRight && !btnLeft) begin
      if (w_px + L_PSTEP > L_PMAX) w_paddleNext = PADDLE_MAX;
      else                         w_paddleNext = r_paddleX + P_STEP;
    end
  end

  // Axes resolve independently so a corner reflects both directions in one frame.
  always_comb begin
    w_ballXNext    = r_ballX;
    w_dirRightNext = r_dirRight;
    w_ballYNext    = r_ballY;
    w_dirUpNext    = r_dirUp;
    w_hit          = 1'b0;
    w_miss         = 1'b0;

    if (r_dirRight) begin
      if (w_bx + L_BS + L_BSTEP >= L_HV) begin
        w_ballXNext    = WALL_X;
        w_dirRightNext = 1'b0;
      end else begin
        w_ballXNext = r_ballX + B_STEP;
      end
    end else begin
      if (w_bx < L_BSTEP) begin
        w_ballXNext    = 10'd0;
        w_dirRightNext = 1'b1;
      end else begin
        w_ballXNext = r_ballX - B_STEP;
      end
    end

    if (r_dirUp) begin
      if (w_by < L_BSTEP) begin
        w_ballYNext = 10'd0;
        w_dirUpNext = 1'b0;
      end else begin
        w_ballYNext = r_ballY - B_STEP;
      end
    end else begin
      w_hit = (w_by + L_BS <= L_PY) && (w_by + L_BS + L_BSTEP >= L_PY) &&
              (w_bx + L_BS > w_px) && (w_bx < w_px + L_PW);
      if (w_hit) begin
        w_ballYNext = PARK_Y;
        w_dirUpNext = 1'b1;
      end else if (w_by + L_BS + L_BSTEP >= L_VV) begin
        w_ballYNext = FLOOR_Y;
        w_miss      = 1'b1;
      end else begin
        w_ballYNext = r_ballY + B_STEP;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_lives     <= LIVES_RST;
      r_paddleX   <= PADDLE_HOME;
      r_ballX     <= PADDLE_HOME + PARK_OFS;
      r_ballY     <= PARK_Y;
      r_dirRight  <= 1'b1;
      r_dirUp     <= 1'b1;
      r_missCnt   <= '0;
      r_frameTick <= 1'b0;
      r_paddleHit <= 1'b0;
    end else begin
      r_frameTick <= w_update;
      r_paddleHit <= 1'b0;
      if (w_update) begin
        case (r_state)
          ST_IDLE: begin
            r_paddleX <= w_paddleNext;
            if (btnServe) begin
              r_state    <= ST_PLAY;
              r_dirRight <= 1'b1;
              r_dirUp    <= 1'b1;
            end else begin
              r_ballX <= w_paddleNext + PARK_OFS;
              r_ballY <= PARK_Y;
            end
          end
          ST_PLAY: begin
            r_paddleX   <= w_paddleNext;
            r_ballX     <= w_ballXNext;
            r_ballY     <= w_ballYNext;
            r_dirRight  <= w_dirRightNext;
            r_dirUp     <= w_dirUpNext;
            r_paddleHit <= w_hit;
            if (w_miss) begin
              r_state   <= ST_MISS;
              r_missCnt <= '0;
              if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
            end
          end
          ST_MISS: begin
            r_paddleX <= w_paddleNext;
            if (r_missCnt == MISS_LAST) begin
              r_missCnt <= '0;
              r_state   <= (r_lives == 2'd0) ? ST_OVER : ST_IDLE;
            end else begin
              r_missCnt <= r_missCnt + 1'b1;
            end
          end
          ST_OVER: begin
            if (btnServe) begin
              r_lives <= LIVES_RST;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign ballX     = r_ballX;
  assign ballY     = r_ballY;
  assign paddleX   = r_paddleX;
  assign lives     = r_lives;
  assign gameState = r_state;
  assign paddleHit = r_paddleHit;
  assign frameTick = r_frameTick;

endmodule

// File: tb/tb_ball_paddle_ctrl.sv
// Directed bench for ball_paddle_ctrl: frames are produced by presenting the
// blanking-start pixel for one clock; expected positions are hand-derived.
module tb_ball_paddle_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       pTick;
  logic [9:0] pixelX;
  logic [9:0] pixelY;
  logic       btnLeft;
  logic       btnRight;
  logic       btnServe;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic [9:0] paddleX;
  logic [1:0] lives;
  logic [1:0] gameState;
  logic       paddleHit;
  logic       frameTick;

  int   checkCount = 0;
  int   passCount  = 0;
  int   hitCount   = 0;
  logic tickAtU, hitAtU, tickAfter, hitAfter;

  ball_paddle_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .pTick     (pTick),
    .pixelX    (pixelX),
    .pixelY    (pixelY),
    .btnLeft   (btnLeft),
    .btnRight  (btnRight),
    .btnServe  (btnServe),
    .ballX     (ballX),
    .ballY     (ballY),
    .paddleX   (paddleX),
    .lives     (lives),
    .gameState (gameState),
    .paddleHit (paddleHit),
    .frameTick (frameTick)
  );

  always #5 clock = ~clock;

  // One frame: update pixel for one clock, then one quiet clock to see the pulses drop.
  task automatic applyStimulus(input logic l, input logic r, input logic s);
    @(negedge clock);
    btnLeft = l; btnRight = r; btnServe = s;
    pTick = 1'b1; pixelX = 10'd0; pixelY = 10'd480;
    @(negedge clock);
    tickAtU = frameTick;
    hitAtU  = paddleHit;
    if (hitAtU === 1'b1) hitCount++;
    pTick = 1'b0; pixelX = 10'd1; pixelY = 10'd0;
    btnLeft = 1'b0; btnRight = 1'b0; btnServe = 1'b0;
    @(negedge clock);
    tickAfter = frameTick;
    hitAfter  = paddleHit;
  endtask

  task automatic runFrames(input int n, input logic l, input logic r, input logic s);
    for (int i = 0; i < n; i++) applyStimulus(l, r, s);
  endtask

  task automatic test_reset();
    reset = 1'b1; pTick = 1'b0; pixelX = 10'd1; pixelY = 10'd0;
    btnLeft = 1'b0; btnRight = 1'b0; btnServe = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      pTick = ~pTick;
    end
    pTick = 1'b1; pixelX = 10'd0; pixelY = 10'd480;
    @(negedge clock);
    checkCount++; if (paddleX !== 10'd288) $display("[TB] FAIL reset_paddleX got %0d want 288", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd316) $display("[TB] FAIL reset_ballX got %0d want 316", ballX); else passCount++;
    checkCount++; if (ballY !== 10'd432) $display("[TB] FAIL reset_ballY got %0d want 432", ballY); else passCount++;
    checkCount++; if (lives !== 2'd3) $display("[TB] FAIL reset_lives got %0d want 3", lives); else passCount++;
    checkCount++; if (gameState !== 2'd0) $display("[TB] FAIL reset_state got %0d want 0", gameState); else passCount++;
    checkCount++; if (frameTick !== 1'b0) $display("[TB] FAIL reset_frameTick got %b want 0", frameTick); else passCount++;
    checkCount++; if (paddleHit !== 1'b0) $display("[TB] FAIL reset_paddleHit got %b want 0", paddleHit); else passCount++;
    reset = 1'b0; pTick = 1'b0;
    @(negedge clock);
    checkCount++; if (frameTick !== 1'b0) $display("[TB] FAIL tick_without_ptick got %b want 0", frameTick); else passCount++;
    pTick = 1'b1; pixelX = 10'd1;
    @(negedge clock);
    checkCount++; if (frameTick !== 1'b0) $display("[TB] FAIL tick_wrong_column got %b want 0", frameTick); else passCount++;
    pTick = 1'b0; pixelY = 10'd0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (tickAtU !== 1'b1) $display("[TB] FAIL first_frameTick got %b want 1", tickAtU); else passCount++;
    checkCount++; if (tickAfter !== 1'b0) $display("[TB] FAIL frameTick_width got %b want 0", tickAfter); else passCount++;
    checkCount++; if (ballX !== 10'd316) $display("[TB] FAIL idle_park_ballX got %0d want 316", ballX); else passCount++;
  endtask

  task automatic test_paddle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkCount++; if (paddleX !== 10'd292) $display("[TB] FAIL paddle_right1 got %0d want 292", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd320) $display("[TB] FAIL track_right1 got %0d want 320", ballX); else passCount++;
    runFrames(99, 1'b0, 1'b1, 1'b0);
    checkCount++; if (paddleX !== 10'd576) $display("[TB] FAIL paddle_sat_right got %0d want 576", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd604) $display("[TB] FAIL track_sat_right got %0d want 604", ballX); else passCount++;
    checkCount++; if (ballY !== 10'd432) $display("[TB] FAIL track_ballY got %0d want 432", ballY); else passCount++;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkCount++; if (paddleX !== 10'd576) $display("[TB] FAIL paddle_both got %0d want 576", paddleX); else passCount++;
    runFrames(150, 1'b1, 1'b0, 1'b0);
    checkCount++; if (paddleX !== 10'd0) $display("[TB] FAIL paddle_sat_left got %0d want 0", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd28) $display("[TB] FAIL track_sat_left got %0d want 28", ballX); else passCount++;
    runFrames(72, 1'b0, 1'b1, 1'b0);
    checkCount++; if (paddleX !== 10'd288) $display("[TB] FAIL paddle_home got %0d want 288", paddleX); else passCount++;
    checkCount++; if (gameState !== 2'd0) $display("[TB] FAIL idle_hold got %0d want 0", gameState); else passCount++;
  endtask

  task automatic test_wall_bounce();
    hitCount = 0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkCount++; if (gameState !== 2'd1) $display("[TB] FAIL serve_state got %0d want 1", gameState); else passCount++;
    checkCount++; if (ballX !== 10'd316 || ballY !== 10'd432) $display("[TB] FAIL serve_ball got %0d,%0d want 316,432", ballX, ballY); else passCount++;
    runFrames(56, 1'b1, 1'b0, 1'b0);
    checkCount++; if (paddleX !== 10'd64) $display("[TB] FAIL play_paddle got %0d want 64", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd428 || ballY !== 10'd320) $display("[TB] FAIL play_n56 got %0d,%0d want 428,320", ballX, ballY); else passCount++;
    runFrames(101, 1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd630 || ballY !== 10'd118) $display("[TB] FAIL play_n157 got %0d,%0d want 630,118", ballX, ballY); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd632 || ballY !== 10'd116) $display("[TB] FAIL right_wall got %0d,%0d want 632,116", ballX, ballY); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd630 || ballY !== 10'd114) $display("[TB] FAIL after_right_wall got %0d,%0d want 630,114", ballX, ballY); else passCount++;
    runFrames(57, 1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd516 || ballY !== 10'd0) $display("[TB] FAIL reach_top got %0d,%0d want 516,0", ballX, ballY); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd514 || ballY !== 10'd0) $display("[TB] FAIL top_wall got %0d,%0d want 514,0", ballX, ballY); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd512 || ballY !== 10'd2) $display("[TB] FAIL after_top_wall got %0d,%0d want 512,2", ballX, ballY); else passCount++;
  endtask

  task automatic test_paddle_bounce();
    runFrames(214, 1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd84 || ballY !== 10'd430) $display("[TB] FAIL pre_hit got %0d,%0d want 84,430", ballX, ballY); else passCount++;
    checkCount++; if (hitCount !== 0) $display("[TB] FAIL spurious_hit got %0d want 0", hitCount); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd82 || ballY !== 10'd432) $display("[TB] FAIL paddle_bounce got %0d,%0d want 82,432", ballX, ballY); else passCount++;
    checkCount++; if (hitAtU !== 1'b1) $display("[TB] FAIL paddleHit_pulse got %b want 1", hitAtU); else passCount++;
    checkCount++; if (hitAfter !== 1'b0) $display("[TB] FAIL paddleHit_width got %b want 0", hitAfter); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd80 || ballY !== 10'd430) $display("[TB] FAIL after_bounce got %0d,%0d want 80,430", ballX, ballY); else passCount++;
    checkCount++; if (hitAtU !== 1'b0) $display("[TB] FAIL paddleHit_repeat got %b want 0", hitAtU); else passCount++;
  endtask

  task automatic test_miss();
    runFrames(451, 1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd444 || ballY !== 10'd470) $display("[TB] FAIL pre_miss got %0d,%0d want 444,470", ballX, ballY); else passCount++;
    checkCount++; if (hitCount !== 1) $display("[TB] FAIL hit_total got %0d want 1", hitCount); else passCount++;
    checkCount++; if (gameState !== 2'd1) $display("[TB] FAIL pre_miss_state got %0d want 1", gameState); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd442 || ballY !== 10'd472) $display("[TB] FAIL miss_ball got %0d,%0d want 442,472", ballX, ballY); else passCount++;
    checkCount++; if (gameState !== 2'd2) $display("[TB] FAIL miss_state got %0d want 2", gameState); else passCount++;
    checkCount++; if (lives !== 2'd2) $display("[TB] FAIL miss_lives got %0d want 2", lives); else passCount++;
    runFrames(59, 1'b0, 1'b1, 1'b1);
    checkCount++; if (gameState !== 2'd2) $display("[TB] FAIL miss_hold got %0d want 2", gameState); else passCount++;
    checkCount++; if (ballX !== 10'd442 || ballY !== 10'd472) $display("[TB] FAIL miss_frozen got %0d,%0d want 442,472", ballX, ballY); else passCount++;
    checkCount++; if (paddleX !== 10'd300) $display("[TB] FAIL miss_paddle got %0d want 300", paddleX); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (gameState !== 2'd0) $display("[TB] FAIL miss_to_idle got %0d want 0", gameState); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd328 || ballY !== 10'd432) $display("[TB] FAIL repark got %0d,%0d want 328,432", ballX, ballY); else passCount++;
    runFrames(3, 1'b1, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd316) $display("[TB] FAIL repark_home got %0d want 316", ballX); else passCount++;
  endtask

  task automatic test_game_over();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      runFrames(453, 1'b0, 1'b0, 1'b0);
      checkCount++; if (gameState !== 2'd2) $display("[TB] FAIL miss%0d_state got %0d want 2", i + 2, gameState); else passCount++;
      checkCount++; if (ballX !== 10'd42 || ballY !== 10'd472) $display("[TB] FAIL miss%0d_ball got %0d,%0d want 42,472", i + 2, ballX, ballY); else passCount++;
      checkCount++; if (lives !== 2'(1 - i)) $display("[TB] FAIL miss%0d_lives got %0d want %0d", i + 2, lives, 1 - i); else passCount++;
      runFrames(59, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkCount++; if (gameState !== ((i == 1) ? 2'd3 : 2'd0)) $display("[TB] FAIL miss%0d_exit got %0d want %0d", i + 2, gameState, (i == 1) ? 3 : 0); else passCount++;
      if (i == 0) applyStimulus(1'b0, 1'b0, 1'b0);
    end
    runFrames(5, 1'b1, 1'b0, 1'b0);
    checkCount++; if (paddleX !== 10'd288) $display("[TB] FAIL over_paddle got %0d want 288", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd42 || ballY !== 10'd472) $display("[TB] FAIL over_ball got %0d,%0d want 42,472", ballX, ballY); else passCount++;
    checkCount++; if (gameState !== 2'd3 || lives !== 2'd0) $display("[TB] FAIL over_hold got %0d/%0d want 3/0", gameState, lives); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkCount++; if (gameState !== 2'd0 || lives !== 2'd3) $display("[TB] FAIL restart got %0d/%0d want 0/3", gameState, lives); else passCount++;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd316 || ballY !== 10'd432) $display("[TB] FAIL restart_park got %0d,%0d want 316,432", ballX, ballY); else passCount++;
  endtask

  task automatic test_reset_at_update();
    applyStimulus(1'b0, 1'b0, 1'b1);
    runFrames(10, 1'b0, 1'b1, 1'b0);
    checkCount++; if (paddleX !== 10'd328) $display("[TB] FAIL midplay_paddle got %0d want 328", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd336 || ballY !== 10'd412) $display("[TB] FAIL midplay_ball got %0d,%0d want 336,412", ballX, ballY); else passCount++;
    @(negedge clock);
    reset = 1'b1; pTick = 1'b1; pixelX = 10'd0; pixelY = 10'd480; btnRight = 1'b1;
    @(negedge clock);
    checkCount++; if (frameTick !== 1'b0 || paddleHit !== 1'b0) $display("[TB] FAIL reset_at_U_pulses got %b%b want 00", frameTick, paddleHit); else passCount++;
    checkCount++; if (paddleX !== 10'd288) $display("[TB] FAIL reset_at_U_paddle got %0d want 288", paddleX); else passCount++;
    checkCount++; if (ballX !== 10'd316 || ballY !== 10'd432) $display("[TB] FAIL reset_at_U_ball got %0d,%0d want 316,432", ballX, ballY); else passCount++;
    checkCount++; if (gameState !== 2'd0 || lives !== 2'd3) $display("[TB] FAIL reset_at_U_state got %0d/%0d want 0/3", gameState, lives); else passCount++;
    reset = 1'b0; pTick = 1'b0; pixelX = 10'd1; pixelY = 10'd0; btnRight = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkCount++; if (ballX !== 10'd318 || ballY !== 10'd430) $display("[TB] FAIL reset_dirs got %0d,%0d want 318,430", ballX, ballY); else passCount++;
  endtask

  initial begin
    test_reset();
    test_paddle();
    test_wall_bounce();
    test_paddle_bounce();
    test_miss();
    test_game_over();
    test_reset_at_update();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ball_paddle_ctrl.md
Name: ball_paddle_ctrl

Overview:
- Per-frame game controller for the Breakout display path.
- Decodes the frame boundary from the VGA sync counters, then sequences paddle motion, ball motion, wall and paddle bounces, misses and lives through a serve/play/miss/over state machine.
- Outputs registered object coordinates that the object renderer turns into pixels.
- All updates happen only at the start of vertical blanking, so objects never tear mid-frame.

Parameters:
H_VISIBLE, 640, visible width in pixels
V_VISIBLE, 480, visible height in lines
BALL_SIZE, 8, ball edge length (square)
PADDLE_W, 64, paddle width
PADDLE_Y, 440, paddle top row (fixed)
PADDLE_STEP, 4, paddle pixels per frame
BALL_STEP, 2, ball pixels per frame per axis
LIVES_INIT, 3, lives at reset and restart
MISS_FRAMES, 60, frames spent in MISS

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
pTick  in  1  pixel-clock enable from VGA_Sync
pixelX  in  10  current column
pixelY  in  10  current line
btnLeft  in  1  move paddle left (level)
btnRight  in  1  move paddle right (level)
btnServe  in  1  serve / restart (level)
ballX  out  10  ball left edge
ballY  out  10  ball top edge
paddleX  out  10  paddle left edge
lives  out  2  remaining lives
gameState  out  2  0=IDLE 1=PLAY 2=MISS 3=OVER
paddleHit  out  1  one-clock pulse on paddle bounce
frameTick  out  1  one-clock pulse, registered update strobe

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - gameState=IDLE, lives=LIVES_INIT.
  - paddleX=(H_VISIBLE-PADDLE_W)/2=288.
  - ballX=paddleX+PADDLE_W/2-BALL_SIZE/2=316, ballY=PADDLE_Y-BALL_SIZE=432.
  - dirX=right, dirY=up, paddleHit=0, frameTick=0, miss counter=0.
  - Reset overrides an update in the same cycle.
- Update edge (U): the rising edge where pTick=1, pixelX=0, pixelY=V_VISIBLE.
  - All state, position and lives registers change only at U.
  - Buttons are sampled at U only.
  - frameTick and paddleHit go high the clock after U, for exactly one clock.
- Paddle, at U in IDLE, PLAY and MISS (frozen in OVER):
  - left only: paddleX -= PADDLE_STEP, saturate at 0.
  - right only: paddleX += PADDLE_STEP, saturate at H_VISIBLE-PADDLE_W.
  - both or neither: hold.
- IDLE:
  - Ball tracks the paddle: ballX=new paddleX+PADDLE_W/2-BALL_SIZE/2, ballY=PADDLE_Y-BALL_SIZE.
  - btnServe at U: go to PLAY with dirX=right, dirY=up. The ball does not move on that U.
- PLAY, per U; X and Y are resolved independently in the same U, so corners bounce both axes:
  - X right: if ballX+BALL_SIZE+BALL_STEP >= H_VISIBLE, set ballX=H_VISIBLE-BALL_SIZE and dirX=left; else ballX += BALL_STEP.
  - X left: if ballX < BALL_STEP, set ballX=0 and dirX=right; else ballX -= BALL_STEP.
  - Y up: if ballY < BALL_STEP, set ballY=0 and dirY=down; else ballY -= BALL_STEP.
  - Y down, paddle hit when all of:
    - ballY+BALL_SIZE <= PADDLE_Y;
    - ballY+BALL_SIZE+BALL_STEP >= PADDLE_Y;
    - ballX+BALL_SIZE > paddleX (pre-update value);
    - ballX < paddleX+PADDLE_W (pre-update value).
    - Result: ballY=PADDLE_Y-BALL_SIZE, dirY=up, pulse paddleHit.
  - Y down, otherwise if ballY+BALL_SIZE+BALL_STEP >= V_VISIBLE: miss.
    - ballY=V_VISIBLE-BALL_SIZE, lives -= 1 (saturate at 0), go to MISS, counter cleared.
  - Y down, otherwise: ballY += BALL_STEP.
  - The paddle test takes priority over the miss test.
- MISS:
  - Ball frozen; counter increments each U.
  - When counter reaches MISS_FRAMES-1 at U: go to OVER if lives==0, else IDLE (ball re-parks on the paddle at the next U).
  - btnServe is ignored.
- OVER:
  - Ball and paddle frozen.
  - btnServe at U: lives=LIVES_INIT, go to IDLE.
- Arithmetic: compare sums at 11 bits to avoid wrap. No output may ever leave its visible range.

Test Plan:
- Reset with pTick toggling → paddleX=288, ballX=316, ballY=432, lives=3, gameState=0. The first frameTick pulse occurs one clock after pixelY=480, pixelX=0, pTick=1.
- btnRight held 100 frames from reset → paddleX climbs by 4 per frame and saturates at 576. ballX tracks at 604 in IDLE. btnLeft+btnRight together → no motion.
- Serve, then force PLAY with ballX=630 moving right and ballY=1 moving up → next U: ballX=632, ballY=0, both directions flip.
- PLAY with ballY=430 moving down, ballX=300, paddleX=288 → next U: ballY=432, dirY=up, paddleHit pulses one clock. Repeat with paddleX=0 → ball continues to 470, then misses: lives=2, gameState=2.
- Three consecutive misses → after 60 frames in MISS with lives==0, gameState=3. Buttons are ignored. btnServe → lives=3, gameState=0.
- Assert reset mid-PLAY coincident with U → all registers take reset values; no paddleHit or frameTick pulse on the following clock.
